// File: rtl/separa_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Inputs above the digit capacity are flagged and the result saturates to all nines.
module separa_seq #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iniciar,
  input  logic [WIDTH-1:0]      numero,
  output logic                  ocupado,
  output logic                  pronto,
  output logic                  estouro,
  output logic [4*DIGITS-1:0]   digitos
);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] MAXV = pow10(DIGITS) - 64'd1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {OCIOSO, CONVERTE, FIM} estado_t;

  estado_t          estado, prox;
  logic [WIDTH-1:0] desloc;
  logic [BW-1:0]    bcd, bcd_ajust, bcd_prox;
  logic [CW-1:0]    cnt;
  logic             ovf;
  logic             aceita, ultimo;

  assign aceita = iniciar && (estado != CONVERTE);
  assign ultimo = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= OCIOSO;
    else        estado <= prox;
  end

  always_comb begin
    prox = estado;
    case (estado)
      OCIOSO:   if (iniciar) prox = CONVERTE;
      CONVERTE: if (ultimo) prox = FIM;
      FIM:      prox = iniciar ? CONVERTE : OCIOSO;
      default:  prox = OCIOSO;
    endcase
  end

  // Add 3 to every nibble >= 5 before the shift, all digits in parallel.
  always_comb begin
    bcd_ajust = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_ajust[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    bcd_prox = (bcd_ajust << 1) | BW'(desloc[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      desloc  <= '0;
      bcd     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      digitos <= '0;
      estouro <= 1'b0;
      ocupado <= 1'b0;
      pronto  <= 1'b0;
    end else begin
      ocupado <= (prox == CONVERTE);
      pronto  <= (prox == FIM);
      if (aceita) begin
        desloc <= numero;
        bcd    <= '0;
        cnt    <= '0;
        ovf    <= (64'(numero) > MAXV);
      end else if (estado == CONVERTE) begin
        desloc <= desloc << 1;
        bcd    <= bcd_prox;
        cnt    <= cnt + CW'(1);
        if (ultimo) begin
          digitos <= ovf ? {DIGITS{4'h9}} : bcd_prox;
          estouro <= ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_separa_seq.sv
// Randomized self-checking bench for separa_seq, three parameter sets side by side,
// compared against a decimal-arithmetic reference model.
module tb_separa_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic ini0 = 0, ini1 = 0, ini2 = 0;
  logic [13:0] num0 = '0;
  logic [7:0]  num1 = '0, num2 = '0;
  logic ocu0, ocu1, ocu2, pro0, pro1, pro2, est0, est1, est2;
  logic [15:0] dig0;
  logic [11:0] dig1;
  logic [7:0]  dig2;

  separa_seq #(.WIDTH(14), .DIGITS(4)) dut0 (.clk(clk), .rst_n(rst_n), .iniciar(ini0), .numero(num0),
    .ocupado(ocu0), .pronto(pro0), .estouro(est0), .digitos(dig0));
  separa_seq #(.WIDTH(8), .DIGITS(3)) dut1 (.clk(clk), .rst_n(rst_n), .iniciar(ini1), .numero(num1),
    .ocupado(ocu1), .pronto(pro1), .estouro(est1), .digitos(dig1));
  separa_seq #(.WIDTH(8), .DIGITS(2)) dut2 (.clk(clk), .rst_n(rst_n), .iniciar(ini2), .numero(num2),
    .ocupado(ocu2), .pronto(pro2), .estouro(est2), .digitos(dig2));

  int widths [3] = '{14, 8, 8};
  int digs   [3] = '{4, 3, 2};
  int passed = 0;
  int total  = 0;

  // Reference: capacity check and decimal digit extraction by division.
  function automatic longint unsigned maxOf(input int d);
    longint unsigned m = 1;
    for (int i = 0; i < d; i++) m = m * 10;
    return m - 1;
  endfunction

  function automatic logic [63:0] refBcd(input longint unsigned v, input int d);
    logic [63:0] r = '0;
    if (v > maxOf(d)) begin
      for (int i = 0; i < d; i++) r[4*i +: 4] = 4'h9;
    end else begin
      for (int i = 0; i < d; i++) begin
        r[4*i +: 4] = 4'(v % 10);
        v = v / 10;
      end
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int sel, input logic ini, input longint unsigned v);
    case (sel)
      0: begin ini0 = ini; num0 = 14'(v); end
      1: begin ini1 = ini; num1 = 8'(v); end
      default: begin ini2 = ini; num2 = 8'(v); end
    endcase
  endtask

  task automatic sample(input int sel, output logic ocu, output logic pro, output logic est,
                        output logic [63:0] dig);
    case (sel)
      0: begin ocu = ocu0; pro = pro0; est = est0; dig = 64'(dig0); end
      1: begin ocu = ocu1; pro = pro1; est = est1; dig = 64'(dig1); end
      default: begin ocu = ocu2; pro = pro2; est = est2; dig = 64'(dig2); end
    endcase
  endtask

  // Full conversion from idle: latency, busy span, result, flag and pulse width.
  task automatic convert(input int sel, input longint unsigned v);
    logic ocu, pro, est;
    logic [63:0] dig;
    int cycles = 0, busy = 0;
    applyStimulus(sel, 1'b1, v);
    tick();
    applyStimulus(sel, 1'b0, v ^ 64'h5a);
    sample(sel, ocu, pro, est, dig);
    while (!pro && cycles < 100) begin
      if (ocu) busy++;
      tick();
      cycles++;
      sample(sel, ocu, pro, est, dig);
    end
    checkOutput($sformatf("latency[%0d] v=%0d", sel, v), 64'(cycles), 64'(widths[sel]));
    checkOutput($sformatf("busy[%0d] v=%0d", sel, v), 64'(busy), 64'(widths[sel]));
    checkOutput($sformatf("digitos[%0d] v=%0d", sel, v), dig, refBcd(v, digs[sel]));
    checkOutput($sformatf("estouro[%0d] v=%0d", sel, v), 64'(est), 64'(v > maxOf(digs[sel])));
    tick();
    sample(sel, ocu, pro, est, dig);
    checkOutput($sformatf("pulse[%0d] v=%0d", sel, v), 64'(pro), 64'd0);
  endtask

  initial begin
    logic ocu, pro, est;
    logic [63:0] dig;
    int pulses, last, first;
    #12;
    checkOutput("reset ocupado", 64'(ocu0), 64'd0);
    checkOutput("reset pronto", 64'(pro0), 64'd0);
    checkOutput("reset estouro", 64'(est0), 64'd0);
    checkOutput("reset digitos", 64'(dig0), 64'd0);
    rst_n = 1'b1;
    tick();

    convert(0, 1234);
    convert(0, 0);
    convert(0, 9999);
    convert(0, 10000);
    convert(0, 16383);
    for (int i = 0; i < 12; i++) convert(0, $urandom_range(0, 16383));

    // Starts during a conversion must be ignored; numero changes after acceptance.
    applyStimulus(0, 1'b1, 1234);
    tick();
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1'b1, 42);
      tick();
      if (pro0) pulses++;
    end
    applyStimulus(0, 1'b0, 42);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pro0) begin pulses++; dig = 64'(dig0); end
    end
    checkOutput("ignore pulses", 64'(pulses), 64'd1);
    checkOutput("ignore digitos", dig, 64'h1234);

    // Start held high: back-to-back restarts from FIM every WIDTH+1 cycles.
    applyStimulus(0, 1'b1, 567);
    pulses = 0; last = -1; first = 1;
    for (int c = 0; c < 120 && pulses < 4; c++) begin
      tick();
      if (pro0) begin
        if (!first) checkOutput("b2b period", 64'(c - last), 64'd15);
        checkOutput("b2b digitos", 64'(dig0), 64'h0567);
        first = 0; last = c; pulses++;
      end
    end
    checkOutput("b2b count", 64'(pulses), 64'd4);
    applyStimulus(0, 1'b0, 0);
    repeat (20) tick();

    convert(1, 255);
    convert(2, 100);
    for (int i = 0; i < 6; i++) begin
      convert(1, $urandom_range(0, 255));
      convert(2, $urandom_range(0, 255));
    end
    convert(1, 0);
    convert(2, 99);
    convert(1, 200);

    // Asynchronous reset mid-conversion aborts without a result.
    applyStimulus(0, 1'b1, 8000);
    tick();
    applyStimulus(0, 1'b0, 8000);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort ocupado", 64'(ocu0), 64'd0);
    checkOutput("abort digitos", 64'(dig0), 64'd0);
    checkOutput("abort estouro", 64'(est0), 64'd0);
    checkOutput("abort digitos dut1", 64'(dig1), 64'd0);
    repeat (3) tick();
    #3 rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (pro0 || ocu0) pulses++;
    end
    checkOutput("abort no activity", 64'(pulses), 64'd0);
    convert(0, 8000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/separa_seq.md
Name: separa_seq

Overview:
- Parametrised, sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm.
- Processes one input bit per clock and returns DIGITS packed BCD digits with a start/busy/done handshake.
- Flags and saturates inputs that exceed the digit capacity.
- Feeds the 7-segment display path in place of divider-based digit splitting, so no wide dividers are needed at larger widths.

Parameters:
- WIDTH, 14, binary input width in bits; legal range 1..32.
- DIGITS, 4, number of BCD output digits; legal range 1..10.
- Derived localparam MAXV = 10^DIGITS - 1, computed in 64-bit arithmetic.

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- rst_n  input  1  asynchronous active-low reset.
- iniciar  input  1  start request; sampled on rising edge of clk.
- numero  input  WIDTH  unsigned binary value; sampled on the edge that accepts iniciar.
- ocupado  output  1  high while a conversion is in progress.
- pronto  output  1  single-cycle pulse: result valid.
- estouro  output  1  numero exceeded MAXV; held with result.
- digitos  output  4*DIGITS  packed BCD; digit 0 (units) in [3:0], digit i in [4i+3:4i]; held until next completion.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately): state=OCIOSO, ocupado=0, pronto=0, estouro=0, digitos=0, internal shift/BCD/counter registers=0.
- A reset asserted mid-conversion aborts it. No pronto is produced. After release the block waits for a new iniciar.
- States:
  - OCIOSO: idle.
  - CONVERTE: ocupado=1.
  - FIM: pronto=1 for exactly one cycle.
- Accepting a start:
  - iniciar is accepted on an edge where state is OCIOSO or FIM.
  - iniciar while state is CONVERTE is ignored: no queuing, current conversion unaffected.
- On the accepting edge (edge k):
  - latch numero into shift register;
  - clear BCD accumulator;
  - cnt=0, state=CONVERTE;
  - latch ovf = (numero > MAXV).
- On each edge in CONVERTE:
  - every BCD nibble >= 5 gets +3 (combinational, all nibbles in parallel);
  - then {bcd, shift} shifts left by 1, MSB of shift enters bcd[0];
  - cnt increments.
  - Bits shifted out of the top nibble are discarded.
- On the WIDTH-th shift edge (edge k+WIDTH):
  - digitos <= post-shift BCD if ovf=0, else all digits 4'h9 (saturation);
  - estouro <= ovf;
  - state=FIM.
- Latency: pronto is high in the cycle after edge k+WIDTH, i.e. exactly WIDTH clocks after the accepting edge. Throughput is one conversion per WIDTH+1 cycles when restarted from FIM, which is legal and back-to-back.
- FIM -> OCIOSO on the next edge unless iniciar is present, in which case FIM -> CONVERTE. pronto deasserts either way.
- numero may change freely after acceptance; only the latched copy is used.
- digitos and estouro change only on the completion edge or on reset; never glitch during CONVERTE.
- WIDTH=1: single shift cycle; behaviour identical with latency 1.
- DIGITS*4 < bit count needed for 2^WIDTH-1: correctness is still guaranteed by ovf saturation.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Default params, numero=1234, iniciar pulse at edge k:
  - ocupado high edges k..k+13;
  - pronto single pulse after edge k+14;
  - digitos=16'h1234, estouro=0.
- numero=0 -> digitos=16'h0000; numero=9999 -> digitos=16'h9999, estouro=0; numero=16383 -> digitos=16'h9999, estouro=1.
- Convert 1234, then assert iniciar repeatedly during CONVERTE with numero=42 -> ignored; result 16'h1234, exactly one pronto.
- iniciar held high continuously with numero=567 -> back-to-back conversions restarted from FIM, pronto every 15 cycles, digitos=16'h0567.
- rst_n low at cycle 5 of a conversion of 8000 -> outputs zero immediately, no pronto; after release, converting 8000 -> 16'h8000.
- WIDTH=8, DIGITS=3: 255 -> 12'h255, latency 8; then WIDTH=8, DIGITS=2: 100 -> 8'h99, estouro=1.
